// File: rtl/fir_frame_pkg.sv
// Shared definitions for the FIR frame controller: command codes, status bits,
// FSM states and the frame byte-offset helper.
package fir_frame_pkg;

    localparam logic [7:0] CMD_PROCESS = 8'h01;
    localparam logic [7:0] CMD_ECHO    = 8'h02;
    localparam logic [7:0] CMD_STATUS  = 8'h03;

    localparam int unsigned STAT_VALID   = 7;
    localparam int unsigned STAT_OVERRUN = 6;
    localparam int unsigned STAT_BADCMD  = 5;
    localparam int unsigned STAT_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        START,
        WAIT,
        RESPOND
    } frameState_t;

    // Byte offset of sample k within a frame (command and tag occupy bytes 0 and 1).
    function automatic int unsigned sampleOffset(input int unsigned k, input int unsigned sampleBytes);
        return 2 + k * sampleBytes;
    endfunction

endpackage

// File: rtl/fir_frame_controller.sv
// Decodes command frames from the SPI slave, sequences the FIR core handshake
// with a timeout, and assembles the response frame for the next SPI exchange.
module fir_frame_controller
    import fir_frame_pkg::*;
#(
    parameter int unsigned PACKET_BYTES   = 8,
    parameter int unsigned SAMPLES_NUM    = 2,
    parameter int unsigned SAMPLE_WIDTH   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                            clkIn,
    input  logic                            resetIn,
    input  logic                            rxValidIn,
    input  logic [PACKET_BYTES*8-1:0]       rxFrameIn,
    output logic [PACKET_BYTES*8-1:0]       txFrameOut,
    output logic                            frameReadyOut,
    output logic                            firStartOut,
    output logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataOut,
    input  logic                            firDoneIn,
    input  logic [SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataIn,
    output logic                            busyOut,
    output logic [7:0]                      overrunCountOut
);

    localparam int unsigned FRAME_W      = PACKET_BYTES * 8;
    localparam int unsigned DATA_W       = SAMPLE_WIDTH * SAMPLES_NUM;
    localparam int unsigned SAMPLE_BYTES = SAMPLE_WIDTH / 8;
    localparam int          TRAIL_BYTES  = int'(PACKET_BYTES) - 2 - int'(SAMPLES_NUM * SAMPLE_BYTES);
    localparam int unsigned CNT_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    frameState_t        state, nextState;
    logic [7:0]         cmdReg, tagReg;
    logic [CNT_W-1:0]   timeoutCnt;
    logic               overrunFlag;
    logic               overrunEvent;
    logic               badCmd;
    logic               timedOut;
    logic [7:0]         respStatus;
    logic [DATA_W-1:0]  rxSamples;
    logic [DATA_W-1:0]  respSamples;
    logic [FRAME_W-17:0] txBody;

    for (genvar k = 0; k < SAMPLES_NUM; k++) begin : gSample
        localparam int unsigned OFF = sampleOffset(k, SAMPLE_BYTES);
        assign rxSamples[(SAMPLES_NUM-k)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH] =
            rxFrameIn[(PACKET_BYTES-OFF)*8-1 -: SAMPLE_WIDTH];
        assign txBody[(PACKET_BYTES-OFF)*8-1 -: SAMPLE_WIDTH] =
            respSamples[(SAMPLES_NUM-k)*SAMPLE_WIDTH-1 -: SAMPLE_WIDTH];
    end

    if (TRAIL_BYTES > 0) begin : gTrail
        logic unusedTrail;
        assign unusedTrail = ^rxFrameIn[TRAIL_BYTES*8-1:0];
        assign txBody[TRAIL_BYTES*8-1:0] = '0;
    end

    assign busyOut      = (state != IDLE);
    assign overrunEvent = rxValidIn && (state != IDLE);
    assign badCmd       = (cmdReg != CMD_PROCESS) && (cmdReg != CMD_ECHO) && (cmdReg != CMD_STATUS);
    // Leaving WAIT without done can only mean the timeout fired.
    assign timedOut     = (state == WAIT) && !firDoneIn;

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (rxValidIn) nextState = DECODE;
            DECODE:  nextState = (cmdReg == CMD_PROCESS) ? START : RESPOND;
            START:   nextState = WAIT;
            WAIT:    if (firDoneIn || timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1)) nextState = RESPOND;
            RESPOND: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        respSamples = '0;
        if (state == WAIT) begin
            if (firDoneIn) respSamples = firDataIn;
        end else if (cmdReg == CMD_ECHO) begin
            respSamples = firDataOut;
        end else begin
            respSamples[DATA_W-1 -: 8] = overrunCountOut;
        end

        respStatus               = '0;
        respStatus[STAT_VALID]   = 1'b1;
        respStatus[STAT_OVERRUN] = overrunFlag || overrunEvent;
        respStatus[STAT_BADCMD]  = badCmd;
        respStatus[STAT_TIMEOUT] = timedOut;
        respStatus[1:0]          = cmdReg[1:0];
    end

    always_ff @(posedge clkIn) begin
        if (resetIn) begin
            state           <= IDLE;
            cmdReg          <= '0;
            tagReg          <= '0;
            timeoutCnt      <= '0;
            overrunFlag     <= 1'b0;
            overrunCountOut <= '0;
            txFrameOut      <= '0;
            frameReadyOut   <= 1'b0;
            firStartOut     <= 1'b0;
            firDataOut      <= '0;
        end else begin
            state         <= nextState;
            firStartOut   <= (nextState == START);
            frameReadyOut <= (nextState == RESPOND);

            if (state == IDLE && rxValidIn) begin
                cmdReg     <= rxFrameIn[FRAME_W-1 -: 8];
                tagReg     <= rxFrameIn[FRAME_W-9 -: 8];
                firDataOut <= rxSamples;
            end

            if (state == START)
                timeoutCnt <= '0;
            else if (state == WAIT)
                timeoutCnt <= timeoutCnt + CNT_W'(1);

            // The response is registered on entry so it lines up with frameReadyOut.
            if (nextState == RESPOND && state != RESPOND)
                txFrameOut <= {respStatus, tagReg, txBody};

            // A drop on the RESPOND cycle must survive the clear and show up next time.
            if (state == RESPOND)
                overrunFlag <= 1'b0;
            if (overrunEvent) begin
                overrunFlag <= 1'b1;
                if (overrunCountOut != 8'hFF)
                    overrunCountOut <= overrunCountOut + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fir_frame_controller.sv
// Directed bench for fir_frame_controller with hand-computed response frames.
module tb_fir_frame_controller;

    logic        clk = 1'b0;
    logic        resetIn = 1'b1;
    logic        rxValidIn = 1'b0;
    logic [63:0] rxFrameIn = '0;
    logic [63:0] txFrameOut;
    logic        frameReadyOut;
    logic        firStartOut;
    logic [31:0] firDataOut;
    logic        firDoneIn = 1'b0;
    logic [31:0] firDataIn = '0;
    logic        busyOut;
    logic [7:0]  overrunCountOut;

    int total = 0;
    int bad = 0;
    int startPulses = 0;
    int readyPulses = 0;

    always #5 clk = ~clk;

    fir_frame_controller #(
        .PACKET_BYTES(8),
        .SAMPLES_NUM(2),
        .SAMPLE_WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clkIn(clk),
        .resetIn(resetIn),
        .rxValidIn(rxValidIn),
        .rxFrameIn(rxFrameIn),
        .txFrameOut(txFrameOut),
        .frameReadyOut(frameReadyOut),
        .firStartOut(firStartOut),
        .firDataOut(firDataOut),
        .firDoneIn(firDoneIn),
        .firDataIn(firDataIn),
        .busyOut(busyOut),
        .overrunCountOut(overrunCountOut)
    );

    task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (firStartOut) startPulses++;
        if (frameReadyOut) readyPulses++;
    endtask

    // Drives a one-cycle rxValidIn pulse; returns during cycle 1 relative to it.
    task automatic sendFrame(input logic [63:0] f);
        rxFrameIn = f;
        rxValidIn = 1'b1;
        tick();
        rxValidIn = 1'b0;
    endtask

    task automatic waitReady(input int maxCycles, input string tag, output int n);
        n = 0;
        while (!frameReadyOut && n < maxCycles) begin
            tick();
            n++;
        end
        checkValue(tag, 64'(frameReadyOut), 64'd1);
    endtask

    task automatic waitIdle(input int maxCycles, input string tag);
        int n = 0;
        while (busyOut && n < maxCycles) begin
            tick();
            n++;
        end
        checkValue(tag, 64'(busyOut), 64'd0);
    endtask

    initial begin
        int n;
        int s;
        int r;

        repeat (3) tick();
        checkValue("rst_tx", txFrameOut, 64'h0);
        checkValue("rst_ready", 64'(frameReadyOut), 64'd0);
        checkValue("rst_start", 64'(firStartOut), 64'd0);
        checkValue("rst_firdata", 64'(firDataOut), 64'h0);
        checkValue("rst_busy", 64'(busyOut), 64'd0);
        checkValue("rst_overrun", 64'(overrunCountOut), 64'h0);
        resetIn = 1'b0;
        tick();

        // PROCESS, FIR returns samples+1 five cycles after start
        sendFrame(64'h015A_1234_ABCD_0000);
        checkValue("p_start_c1", 64'(firStartOut), 64'd0);
        checkValue("p_busy_c1", 64'(busyOut), 64'd1);
        tick();
        checkValue("p_start_c2", 64'(firStartOut), 64'd1);
        checkValue("p_firdata", 64'(firDataOut), 64'h1234ABCD);
        repeat (5) tick();
        checkValue("p_ready_c7", 64'(frameReadyOut), 64'd0);
        firDoneIn = 1'b1;
        firDataIn = 32'h1235_ABCE;
        tick();
        firDoneIn = 1'b0;
        checkValue("p_ready_c8", 64'(frameReadyOut), 64'd1);
        checkValue("p_tx", txFrameOut, 64'h815A_1235_ABCE_0000);
        tick();
        checkValue("p_ready_c9", 64'(frameReadyOut), 64'd0);
        checkValue("p_idle", 64'(busyOut), 64'd0);

        // ECHO
        s = startPulses;
        sendFrame(64'h0207_FFFF_8000_0000);
        checkValue("e_ready_c1", 64'(frameReadyOut), 64'd0);
        tick();
        checkValue("e_ready_c2", 64'(frameReadyOut), 64'd1);
        checkValue("e_tx", txFrameOut, 64'h8207_FFFF_8000_0000);
        tick();
        checkValue("e_nostart", 64'(startPulses), 64'(s));

        // PROCESS with no done: START at 2, WAIT 3..18, RESPOND at 19
        sendFrame(64'h0133_0001_0002_0000);
        waitReady(40, "t_ready", n);
        checkValue("t_latency", 64'(n), 64'd18);
        checkValue("t_tx", txFrameOut, 64'h9133_0000_0000_0000);
        tick();
        checkValue("t_idle", 64'(busyOut), 64'd0);

        // Overrun during WAIT, then done
        sendFrame(64'h0111_0101_0202_0000);
        repeat (2) tick();
        rxFrameIn = 64'h0299_1111_2222_0000;
        rxValidIn = 1'b1;
        tick();
        rxValidIn = 1'b0;
        checkValue("o_count", 64'(overrunCountOut), 64'd1);
        firDoneIn = 1'b1;
        firDataIn = 32'hCAFE_F00D;
        tick();
        firDoneIn = 1'b0;
        checkValue("o_ready", 64'(frameReadyOut), 64'd1);
        checkValue("o_tx", txFrameOut, 64'hC111_CAFE_F00D_0000);
        tick();
        sendFrame(64'h0322_AAAA_BBBB_CCCC);
        tick();
        checkValue("s_ready", 64'(frameReadyOut), 64'd1);
        checkValue("s_tx", txFrameOut, 64'h8322_0100_0000_0000);
        tick();

        // Continuous rx with no FIR done: overrun counter must saturate
        rxFrameIn = 64'h0144_0000_0000_0000;
        rxValidIn = 1'b1;
        repeat (400) tick();
        rxValidIn = 1'b0;
        waitIdle(40, "sat_idle");
        checkValue("sat_count", 64'(overrunCountOut), 64'hFF);
        sendFrame(64'h0355_0000_0000_0000);
        waitReady(10, "sat_status_ready", n);
        checkValue("sat_status_b2", 64'(txFrameOut[47:40]), 64'hFF);
        checkValue("sat_status_tag", 64'(txFrameOut[55:48]), 64'h55);
        tick();
        sendFrame(64'h7E66_1111_2222_3333);
        tick();
        checkValue("bad_ready", 64'(frameReadyOut), 64'd1);
        checkValue("bad_tx", txFrameOut, 64'hA266_FF00_0000_0000);
        tick();

        // Reset while in WAIT, then a late done must be ignored
        sendFrame(64'h0177_1234_5678_0000);
        repeat (2) tick();
        resetIn = 1'b1;
        tick();
        resetIn = 1'b0;
        r = readyPulses;
        firDoneIn = 1'b1;
        firDataIn = 32'h5555_5555;
        tick();
        firDoneIn = 1'b0;
        repeat (5) tick();
        checkValue("r_tx", txFrameOut, 64'h0);
        checkValue("r_ready", 64'(frameReadyOut), 64'd0);
        checkValue("r_start", 64'(firStartOut), 64'd0);
        checkValue("r_firdata", 64'(firDataOut), 64'h0);
        checkValue("r_busy", 64'(busyOut), 64'd0);
        checkValue("r_overrun", 64'(overrunCountOut), 64'h0);
        checkValue("r_nopulse", 64'(readyPulses), 64'(r));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_frame_controller.md
Name: fir_frame_controller

Overview:
Packet-level controller between the SPI slave and the FIR filter core. It decodes a command header in each received SPI frame and extracts SAMPLES_NUM samples. It sequences the FIR start/done handshake with a timeout, then assembles a response frame for the next SPI exchange. The response carries status, an echoed tag and the results. This replaces fixed top-level slicing with parametrised framing, multiple command modes, overrun detection and timeout recovery.

Parameters:
PACKET_BYTES, 8, SPI frame length in bytes. Must satisfy PACKET_BYTES >= 2 + SAMPLES_NUM*SAMPLE_WIDTH/8.
SAMPLES_NUM, 2, samples per frame handed to the FIR core.
SAMPLE_WIDTH, 16, bits per sample. Must be a multiple of 8.
TIMEOUT_CYCLES, 1024, maximum cycles to wait for firDoneIn.

Ports:
clkIn  in  1  system clock.
resetIn  in  1  synchronous, active-high reset.
rxValidIn  in  1  one-cycle pulse: rxFrameIn holds a complete frame.
rxFrameIn  in  PACKET_BYTES*8  received frame. Byte 0 is at the MSBs.
txFrameOut  out  PACKET_BYTES*8  response frame presented to the SPI slave.
frameReadyOut  out  1  one-cycle pulse when txFrameOut is updated.
firStartOut  out  1  one-cycle start pulse to the FIR core.
firDataOut  out  SAMPLE_WIDTH*SAMPLES_NUM  samples to the FIR core. Sample 0 is at the MSBs.
firDoneIn  in  1  one-cycle pulse: firDataIn is valid.
firDataIn  in  SAMPLE_WIDTH*SAMPLES_NUM  filtered samples. Sample 0 is at the MSBs.
busyOut  out  1  high whenever the FSM is not in IDLE.
overrunCountOut  out  8  saturating count of dropped frames.

Behaviour:
- Clock and reset: one clock, clkIn. resetIn is synchronous and active-high.
- Reset values: txFrameOut=0, frameReadyOut=0, firStartOut=0, firDataOut=0, busyOut=0, overrunCountOut=0, sticky flags cleared, FSM=IDLE.
- Reset mid-operation: abandon the transaction; a later firDoneIn is ignored.
- Frame layout:
  - byte0 = command; byte1 = tag.
  - Sample k occupies bytes 2+2k.. (big-endian, SAMPLE_WIDTH/8 bytes each).
  - Unused trailing bytes are ignored on receive and driven 0 on transmit.
- Commands:
  - 0x01 PROCESS: run the FIR core.
  - 0x02 ECHO: return the received samples unchanged.
  - 0x03 STATUS: samples field = 0, except byte 2 = overrunCountOut.
  - Any other value is BAD: same response as STATUS, with the BADCMD bit set.
- Response status byte (byte0):
  - bit7 VALID, always 1.
  - bit6 OVERRUN: a frame was dropped since the last response.
  - bit5 BADCMD.
  - bit4 TIMEOUT.
  - bits1:0 = low two bits of the command.
  - Byte1 = the received tag.
- FSM states: IDLE, DECODE, START, WAIT, RESPOND.
  - IDLE: on rxValidIn, latch cmd, tag and samples, then go to DECODE.
  - DECODE: PROCESS goes to START; all other commands go to RESPOND.
  - START: firDataOut already holds the samples; pulse firStartOut for 1 cycle; clear the timeout counter; go to WAIT.
  - WAIT: on firDoneIn, latch firDataIn and go to RESPOND. If the counter reaches TIMEOUT_CYCLES-1 without done, set TIMEOUT, samples = 0, go to RESPOND.
  - RESPOND: write txFrameOut, pulse frameReadyOut, clear the OVERRUN sticky flag, return to IDLE.
- Latency, with rxValidIn at cycle 0:
  - ECHO, STATUS or BAD: frameReadyOut at cycle 2.
  - PROCESS: firStartOut at cycle 2; firDoneIn at cycle d gives frameReadyOut at cycle d+1.
- Overrun: rxValidIn in any state other than IDLE drops the frame. overrunCountOut increments, saturating at 255, and the OVERRUN sticky flag is set.
- Simultaneous firDoneIn and rxValidIn in WAIT: the done is processed; the rx frame counts as an overrun.
- Overrun on the RESPOND cycle: the sticky flag is set after clear, so it is reported in the following response.
- Timeout counter width: $clog2(TIMEOUT_CYCLES).
- firDoneIn outside WAIT is ignored.
- txFrameOut holds its value between responses.

Decomposition:
- Package fir_frame_pkg holds:
  - the command codes;
  - the status bit indices;
  - the FSM state enum;
  - a function that returns the byte offset of sample k.
- No sub-module is needed. Pack and unpack use generate loops inside this module.

Test Plan:
- Reset, then PROCESS frame 01 5A 1234 ABCD 0000, FIR model echoes samples+1 with done 5 cycles after start -> firStartOut at cycle 2, firDataOut=1234ABCD; txFrameOut=81 5A 1235 ABCE 0000, frameReadyOut at cycle 8.
- ECHO frame 02 07 FFFF 8000 0000 -> frameReadyOut at cycle 2; txFrameOut=82 07 FFFF 8000 0000; firStartOut never asserted.
- PROCESS with no firDoneIn, TIMEOUT_CYCLES=16 -> txFrameOut=91 tag 0000 0000 0000 after timeout expiry; busyOut returns low.
- Second rxValidIn during WAIT, then done -> first response byte0=C1 (OVERRUN), overrunCountOut=1; the following STATUS response byte0=83, byte2=01.
- 300 rxValidIn pulses while held in WAIT -> overrunCountOut saturates at FF. Command 0x7E -> byte0=A2 (BADCMD).
- resetIn asserted in WAIT, then late firDoneIn -> all outputs 0; no frameReadyOut.
